demux_dispatch_ctrl: RTL
========================

DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8: data word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the source offers a word.
REQ-005 The block SHALL have port in_data, input, DW bits: the source word.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = round-robin dispatch, 1 = directed dispatch.
REQ-008 The block SHALL have port dest, input, 2 bits: destination channel in directed mode; sampled at accept.
REQ-009 The block SHALL have port chan_en, input, 4 bits: per-channel enable mask.
REQ-010 The block SHALL have port chan_ready, input, 4 bits: per-channel sink ready.
REQ-011 The block SHALL have port sel, output, 2 bits: demux select; sel[1] drives the demux MSB select and sel[0] the LSB select.
REQ-012 The block SHALL have port out_valid, output, 4 bits: one-hot valid at index sel.
REQ-013 The block SHALL have port out_data, output, DW bits: registered word presented to the demux data input.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse when a word is dropped.
REQ-015 The block SHALL have port dcount, output, 8 bits: count of delivered words, wrapping modulo 256.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SEND, DROP.
REQ-017 in_ready SHALL be 1 only in IDLE, and only when mode=1 or chan_en!=0.
REQ-018 Accept SHALL occur when in_valid and in_ready are both 1: in_data is latched into out_data and sel is computed.
REQ-019 In round-robin mode, sel SHALL be the first enabled channel found searching ptr, ptr+1, ... modulo 4.
REQ-020 In directed mode, sel SHALL be dest.
REQ-021 After accept, the next state SHALL be SEND if chan_en[sel]=1, else DROP.
REQ-022 In SEND, out_valid[sel] SHALL be 1 and all other out_valid bits 0; out_data and sel SHALL be held stable.
REQ-023 A SEND cycle with chan_ready[sel]=1 and chan_en[sel]=1 SHALL deliver the word: next state IDLE, dcount+1, ptr<=sel+1 mod 4.
REQ-024 A SEND cycle with chan_ready[sel]=0 and chan_en[sel]=1 SHALL stay in SEND with no timeout.
REQ-025 A SEND cycle with chan_en[sel]=0 SHALL abort: the word is dropped, next state DROP, ptr and dcount unchanged; chan_en takes priority over chan_ready.
REQ-026 The DROP state SHALL last one cycle with err=1 and out_valid=0, then return to IDLE.
REQ-027 err SHALL be 0 in all states other than DROP.
REQ-028 Minimum throughput SHALL be 1 word per 2 cycles: accept, then deliver on the first SEND cycle.
REQ-029 dcount SHALL wrap from 255 to 0.
REQ-030 ptr SHALL not advance on a drop.
REQ-031 Changes to mode or dest while in SEND SHALL not affect the word in flight.
REQ-032 No output SHALL depend combinationally on chan_ready; in_ready depends only on state, mode and chan_en.

Reset
REQ-033 While rst_n=0, state SHALL be IDLE, ptr=0, sel=0, out_data=0, out_valid=0, err=0, dcount=0, asynchronously.
REQ-034 An rst_n assertion during SEND SHALL discard the word immediately, with no err pulse.
REQ-035 After rst_n deasserts, the first accept SHALL be possible on the next rising clock edge.

Verification
REQ-036 Round-robin, chan_en=1111, chan_ready=1111, 4 words A1,A2,A3,A4 -> sel=0,1,2,3; out_valid=0001,0010,0100,1000; dcount=4; each word 2 cycles.
REQ-037 Round-robin, chan_en=1010, 3 words -> sel=1,3,1; channels 0 and 2 never valid.
REQ-038 Directed mode, dest=2, chan_ready[2]=0 for 5 cycles then 1 -> out_valid=0100 held 6 cycles, out_data stable, dcount+1 on the 6th cycle.
REQ-039 Directed mode, dest=1, chan_en=1101 -> word accepted, err=1 for exactly one cycle, out_valid never set, dcount unchanged.
REQ-040 SEND to ch0 stalled, then chan_en[0] cleared -> next cycle err=1, out_valid=0, then IDLE; the next round-robin accept selects ch0's successor by ptr (ptr still 0, so first enabled channel from 0).
REQ-041 rst_n pulsed low mid-SEND, and separately 256 deliveries -> all outputs 0 asynchronously; dcount wraps to 0.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : demux_dispatch_ctrl
//  Purpose  : Steers single words from a valid/ready source to one of four
//             sink channels through an external 1-to-4 demux, using either
//             round-robin or directed channel selection.
//  Revision : 1.0  initial release
// ============================================================================
module demux_dispatch_ctrl #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic          mode,
   input  logic [1:0]    dest,
   input  logic [3:0]    chan_en,
   input  logic [3:0]    chan_ready,
   output logic [1:0]    sel,
   output logic [3:0]    out_valid,
   output logic [DW-1:0] out_data,
   output logic          err,
   output logic [7:0]    dcount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    ptr_q,   ptr_d;
   logic [1:0]    sel_q,   sel_d;
   logic [DW-1:0] data_q,  data_d;
   logic [7:0]    cnt_q,   cnt_d;

   logic [1:0]    w_rr_sel;
   logic [1:0]    w_acc_sel;
   logic          w_accept;

   // Scan offsets from the far end down so the closest enabled channel to ptr wins.
   always_comb begin
      w_rr_sel = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         if (chan_en[ptr_q + 2'(i)]) begin
            w_rr_sel = ptr_q + 2'(i);
         end
      end
   end

   assign in_ready  = (state_q == IDLE) && (mode || (chan_en != 4'b0000));
   assign w_accept  = in_valid && in_ready;
   assign w_acc_sel = mode ? dest : w_rr_sel;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (w_accept) begin
               data_d  = in_data;
               sel_d   = w_acc_sel;
               state_d = chan_en[w_acc_sel] ? SEND : DROP;
            end
         end
         SEND: begin
            // A disabled channel aborts the word even if its sink is ready.
            if (!chan_en[sel_q]) begin
               state_d = DROP;
            end else if (chan_ready[sel_q]) begin
               state_d = IDLE;
               cnt_d   = cnt_q + 8'd1;
               ptr_d   = sel_q + 2'd1;
            end
         end
         DROP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         data_q  <= '0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sel       = sel_q;
   assign out_data  = data_q;
   assign out_valid = (state_q == SEND) ? (4'b0001 << sel_q) : 4'b0000;
   assign err       = (state_q == DROP);
   assign dcount    = cnt_q;

endmodule
`default_nettype wire
